// File: rtl/drive_pkg.sv
// Shared definitions for the motor drive command path: one-hot bit indices,
// the STOP command, forward/backward direction masks and arbiter states.
package drive_pkg;

   localparam int unsigned CMD_W    = 9;

   localparam int unsigned BIT_W    = 0;
   localparam int unsigned BIT_S    = 1;
   localparam int unsigned BIT_A    = 2;
   localparam int unsigned BIT_D    = 3;
   localparam int unsigned BIT_WA   = 4;
   localparam int unsigned BIT_WD   = 5;
   localparam int unsigned BIT_AS   = 6;
   localparam int unsigned BIT_DS   = 7;
   localparam int unsigned BIT_STOP = 8;

   localparam logic [CMD_W-1:0] CMD_STOP = 9'h001 << BIT_STOP;

   // Forward-moving commands: w, wa, wd
   localparam logic [CMD_W-1:0] FWD_MASK = (9'h001 << BIT_W) | (9'h001 << BIT_WA) | (9'h001 << BIT_WD);
   // Backward-moving commands: s, as, ds
   localparam logic [CMD_W-1:0] BWD_MASK = (9'h001 << BIT_S) | (9'h001 << BIT_AS) | (9'h001 << BIT_DS);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_AUTO     = 3'd1,
      ST_MANUAL   = 3'd2,
      ST_DEADTIME = 3'd3,
      ST_FAULT    = 3'd4
   } arb_state_t;

   // True when exactly one bit of the command is set
   function automatic logic is_onehot(input logic [CMD_W-1:0] cmd);
      return (cmd != 9'h000) && ((cmd & (cmd - 9'h001)) == 9'h000);
   endfunction

endpackage

// File: rtl/cmd_classify.sv
// Combinational classifier for a 9-bit drive command: reports whether it is
// a forward or backward motion and whether it is a legal one-hot value.
module cmd_classify
   import drive_pkg::*;
(
   input  logic [CMD_W-1:0] cmd,
   output logic             is_fwd,
   output logic             is_bwd,
   output logic             valid_onehot
);

   assign valid_onehot = is_onehot(cmd);
   assign is_fwd       = |(cmd & FWD_MASK);
   assign is_bwd       = |(cmd & BWD_MASK);

endmodule

// File: rtl/drive_cmd_arbiter.sv
// Motor drive command arbiter: selects manual or autonomous source, inserts a
// STOP dead-time on mode switches and direction reversals, honours estop and
// (when DRIVE_ARB_WATCHDOG_EN is defined) times out an idle manual link.
module drive_cmd_arbiter
   import drive_pkg::*;
#(
   parameter int unsigned DEADTIME_CYCLES = 5_000_000,
   parameter int unsigned WATCHDOG_CYCLES = 50_000_000,
   parameter int unsigned CNT_W           = 26
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             manual_on,
   input  logic [CMD_W-1:0] man_cmd,
   input  logic             man_valid,
   input  logic [CMD_W-1:0] auto_cmd,
   input  logic             estop,
   output logic [CMD_W-1:0] drive_cmd,
   output logic             active_src,
   output logic             in_deadtime,
   output logic             wd_timeout,
   output logic             cmd_err
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] DT_LAST  = CNT_W'(DEADTIME_CYCLES - 1);

   arb_state_t       state_r, state_s;
   logic             tgt_manual_r, tgt_manual_s;
   logic [CNT_W-1:0] dt_cnt_r, dt_cnt_s;
   logic [CMD_W-1:0] drive_cmd_r, cmd_s;
   logic             active_src_r;
   logic             in_deadtime_r;
   logic             cmd_err_r, err_s;

   logic cur_fwd_s, cur_bwd_s, unused_cur_ok_s;
   logic auto_fwd_s, auto_bwd_s, auto_ok_s;
   logic man_fwd_s, man_bwd_s, man_ok_s;
   logic auto_rev_s, man_rev_s;

`ifdef DRIVE_ARB_WATCHDOG_EN
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WATCHDOG_CYCLES - 1);
   logic [CNT_W-1:0] wd_cnt_r, wd_cnt_s;
   logic             wd_exp_r, wd_exp_s;
`else
   localparam int unsigned unused_wd_limit = WATCHDOG_CYCLES;
   logic unused_man_valid_s;
   assign unused_man_valid_s = man_valid;
`endif

   cmd_classify u_cur_cls (
      .cmd          (drive_cmd_r),
      .is_fwd       (cur_fwd_s),
      .is_bwd       (cur_bwd_s),
      .valid_onehot (unused_cur_ok_s)
   );

   cmd_classify u_auto_cls (
      .cmd          (auto_cmd),
      .is_fwd       (auto_fwd_s),
      .is_bwd       (auto_bwd_s),
      .valid_onehot (auto_ok_s)
   );

   cmd_classify u_man_cls (
      .cmd          (man_cmd),
      .is_fwd       (man_fwd_s),
      .is_bwd       (man_bwd_s),
      .valid_onehot (man_ok_s)
   );

   // An invalid source value counts as STOP, which is neutral and never reverses
   assign auto_rev_s = auto_ok_s && ((cur_fwd_s && auto_bwd_s) || (cur_bwd_s && auto_fwd_s));
   assign man_rev_s  = man_ok_s  && ((cur_fwd_s && man_bwd_s)  || (cur_bwd_s && man_fwd_s));

   // Next-state, counter and next-output selection
   always_comb begin
      state_s      = state_r;
      tgt_manual_s = tgt_manual_r;
      dt_cnt_s     = dt_cnt_r;
      cmd_s        = CMD_STOP;
      err_s        = 1'b0;
`ifdef DRIVE_ARB_WATCHDOG_EN
      wd_cnt_s     = CNT_ZERO;
      wd_exp_s     = 1'b0;
`endif
      if (estop) begin
         state_s  = ST_FAULT;
         dt_cnt_s = CNT_ZERO;
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_s      = ST_DEADTIME;
               tgt_manual_s = manual_on;
               dt_cnt_s     = CNT_ZERO;
            end
            ST_AUTO: begin
               if (manual_on) begin
                  state_s      = ST_DEADTIME;
                  tgt_manual_s = 1'b1;
                  dt_cnt_s     = CNT_ZERO;
               end else if (auto_rev_s) begin
                  state_s      = ST_DEADTIME;
                  tgt_manual_s = 1'b0;
                  dt_cnt_s     = CNT_ZERO;
               end else begin
                  cmd_s = auto_ok_s ? auto_cmd : CMD_STOP;
                  err_s = ~auto_ok_s;
               end
            end
            ST_MANUAL: begin
               if (!manual_on) begin
                  state_s      = ST_DEADTIME;
                  tgt_manual_s = 1'b0;
                  dt_cnt_s     = CNT_ZERO;
               end else if (man_rev_s) begin
                  state_s      = ST_DEADTIME;
                  tgt_manual_s = 1'b1;
                  dt_cnt_s     = CNT_ZERO;
               end else begin
`ifdef DRIVE_ARB_WATCHDOG_EN
                  if (man_valid) begin
                     cmd_s = man_ok_s ? man_cmd : CMD_STOP;
                     err_s = ~man_ok_s;
                  end else if (wd_exp_r || (wd_cnt_r == WD_LAST)) begin
                     wd_cnt_s = wd_cnt_r;
                     wd_exp_s = 1'b1;
                  end else begin
                     wd_cnt_s = wd_cnt_r + CNT_ONE;
                     cmd_s    = man_ok_s ? man_cmd : CMD_STOP;
                     err_s    = ~man_ok_s;
                  end
`else
                  cmd_s = man_ok_s ? man_cmd : CMD_STOP;
                  err_s = ~man_ok_s;
`endif
               end
            end
            ST_DEADTIME: begin
               if (manual_on != tgt_manual_r) begin
                  tgt_manual_s = manual_on;
                  dt_cnt_s     = CNT_ZERO;
               end else if (dt_cnt_r == DT_LAST) begin
                  dt_cnt_s = CNT_ZERO;
                  if (tgt_manual_r) begin
                     state_s = ST_MANUAL;
                     cmd_s   = man_ok_s ? man_cmd : CMD_STOP;
                     err_s   = ~man_ok_s;
                  end else begin
                     state_s = ST_AUTO;
                     cmd_s   = auto_ok_s ? auto_cmd : CMD_STOP;
                     err_s   = ~auto_ok_s;
                  end
               end else begin
                  dt_cnt_s = dt_cnt_r + CNT_ONE;
               end
            end
            ST_FAULT: begin
               state_s  = ST_IDLE;
               dt_cnt_s = CNT_ZERO;
            end
            default: begin
               state_s  = ST_IDLE;
               dt_cnt_s = CNT_ZERO;
            end
         endcase
      end
   end

   // State register, dead-time counter and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         tgt_manual_r  <= 1'b0;
         dt_cnt_r      <= CNT_ZERO;
         drive_cmd_r   <= CMD_STOP;
         active_src_r  <= 1'b0;
         in_deadtime_r <= 1'b0;
         cmd_err_r     <= 1'b0;
      end else begin
         state_r       <= state_s;
         tgt_manual_r  <= tgt_manual_s;
         dt_cnt_r      <= dt_cnt_s;
         drive_cmd_r   <= cmd_s;
         active_src_r  <= (state_s == ST_MANUAL);
         in_deadtime_r <= (state_s == ST_DEADTIME);
         cmd_err_r     <= err_s;
      end
   end

`ifdef DRIVE_ARB_WATCHDOG_EN
   // Manual-link watchdog counter and expiry flag
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt_r <= CNT_ZERO;
         wd_exp_r <= 1'b0;
      end else begin
         wd_cnt_r <= wd_cnt_s;
         wd_exp_r <= wd_exp_s;
      end
   end

   assign wd_timeout = wd_exp_r;
`else
   assign wd_timeout = 1'b0;
`endif

   assign drive_cmd   = drive_cmd_r;
   assign active_src  = active_src_r;
   assign in_deadtime = in_deadtime_r;
   assign cmd_err     = cmd_err_r;

endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// Self-checking bench for drive_cmd_arbiter with randomized command streams
// checked against a rule-level reference model (direction groups, dead-time
// length, watchdog idle count).
module tb_drive_cmd_arbiter;

   localparam int DT = 4;
   localparam int WD = 16;
   localparam logic [8:0] STOP = 9'h100;
`ifdef DRIVE_ARB_WATCHDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       manual_on = 1'b0;
   logic       man_valid = 1'b0;
   logic       estop = 1'b0;
   logic [8:0] man_cmd = 9'h100;
   logic [8:0] auto_cmd = 9'h100;
   logic [8:0] drive_cmd;
   logic       active_src, in_deadtime, wd_timeout, cmd_err;

   int         checks = 0;
   int         failures = 0;
   logic [8:0] cur;
   int         since;

   always #5 clk = ~clk;

   drive_cmd_arbiter #(
      .DEADTIME_CYCLES (DT),
      .WATCHDOG_CYCLES (WD),
      .CNT_W           (26)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .manual_on   (manual_on),
      .man_cmd     (man_cmd),
      .man_valid   (man_valid),
      .auto_cmd    (auto_cmd),
      .estop       (estop),
      .drive_cmd   (drive_cmd),
      .active_src  (active_src),
      .in_deadtime (in_deadtime),
      .wd_timeout  (wd_timeout),
      .cmd_err     (cmd_err)
   );

   // Direction group by command name: 1 forward, 2 backward, 0 neutral
   function automatic int grp(input logic [8:0] c);
      case (c)
         9'h001, 9'h010, 9'h020: return 1;
         9'h002, 9'h040, 9'h080: return 2;
         default:                return 0;
      endcase
   endfunction

   function automatic bit reversal(input logic [8:0] from_c, input logic [8:0] to_c);
      return (grp(from_c) != 0) && (grp(to_c) != 0) && (grp(from_c) != grp(to_c));
   endfunction

   function automatic logic [12:0] obs();
      return {drive_cmd, active_src, in_deadtime, wd_timeout, cmd_err};
   endfunction

   function automatic logic [8:0] rand_valid();
      logic [8:0] one;
      one = 9'h001;
      return one << $urandom_range(0, 8);
   endfunction

   function automatic logic [8:0] rand_invalid();
      logic [8:0] v;
      v = 9'($urandom_range(0, 511));
      while ($countones(v) == 1) v = 9'($urandom_range(0, 511));
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [12:0] e;
      step();
      step();
      e = {STOP, 1'b0, 1'b0, 1'b0, 1'b0};
      if (obs() !== e) begin failures++; $display("FAIL reset_state got=%h want=%h", obs(), e); end
      checks++;
      manual_on = 1'b0;
      auto_cmd  = 9'h001;
      rst       = 1'b0;
      for (int k = 0; k < DT; k++) begin
         step();
         e = {STOP, 1'b0, 1'b1, 1'b0, 1'b0};
         if (obs() !== e) begin failures++; $display("FAIL reset_deadtime cyc=%0d got=%h want=%h", k, obs(), e); end
         checks++;
      end
      step();
      e = {9'h001, 1'b0, 1'b0, 1'b0, 1'b0};
      if (obs() !== e) begin failures++; $display("FAIL reset_first_cmd got=%h want=%h", obs(), e); end
      checks++;
      cur = 9'h001;
   endtask

   task automatic test_auto();
      logic [8:0]  seq[$];
      logic [8:0]  nw;
      logic [12:0] e;
      seq = '{9'h002, 9'h001, 9'h004};
      for (int i = 0; i < 25; i++) seq.push_back(rand_valid());
      foreach (seq[i]) begin
         nw = seq[i];
         auto_cmd = nw;
         if (reversal(cur, nw)) begin
            for (int k = 0; k < DT; k++) begin
               step();
               e = {STOP, 1'b0, 1'b1, 1'b0, 1'b0};
               if (obs() !== e) begin failures++; $display("FAIL auto_reversal_stop i=%0d got=%h want=%h", i, obs(), e); end
               checks++;
            end
         end
         step();
         e = {nw, 1'b0, 1'b0, 1'b0, 1'b0};
         if (obs() !== e) begin failures++; $display("FAIL auto_follow i=%0d got=%h want=%h", i, obs(), e); end
         checks++;
         cur = nw;
      end
   endtask

   task automatic test_invalid();
      logic [8:0]  bad;
      logic [8:0]  nw;
      logic [12:0] e;
      for (int i = 0; i < 6; i++) begin
         bad = (i == 0) ? 9'h003 : rand_invalid();
         auto_cmd = bad;
         step();
         e = {STOP, 1'b0, 1'b0, 1'b0, 1'b1};
         if (obs() !== e) begin failures++; $display("FAIL invalid_stop_err i=%0d in=%h got=%h want=%h", i, bad, obs(), e); end
         checks++;
         nw = rand_valid();
         auto_cmd = nw;
         step();
         e = {nw, 1'b0, 1'b0, 1'b0, 1'b0};
         if (obs() !== e) begin failures++; $display("FAIL invalid_recover i=%0d got=%h want=%h", i, obs(), e); end
         checks++;
         cur = nw;
      end
   endtask

   task automatic test_mode_switch();
      logic [12:0] e;
      man_cmd   = 9'h020;
      man_valid = 1'b0;
      manual_on = 1'b1;
      for (int k = 0; k < DT; k++) begin
         step();
         e = {STOP, 1'b0, 1'b1, 1'b0, 1'b0};
         if (obs() !== e) begin failures++; $display("FAIL switch_to_man_dt cyc=%0d got=%h want=%h", k, obs(), e); end
         checks++;
      end
      for (int k = 0; k < 2; k++) begin
         step();
         e = {9'h020, 1'b1, 1'b0, 1'b0, 1'b0};
         if (obs() !== e) begin failures++; $display("FAIL switch_man_out cyc=%0d got=%h want=%h", k, obs(), e); end
         checks++;
      end
      auto_cmd  = 9'h010;
      manual_on = 1'b0;
      for (int k = 0; k < 2; k++) begin
         step();
         e = {STOP, 1'b0, 1'b1, 1'b0, 1'b0};
         if (obs() !== e) begin failures++; $display("FAIL toggle_pre cyc=%0d got=%h want=%h", k, obs(), e); end
         checks++;
      end
      manual_on = 1'b1;
      for (int k = 0; k < DT; k++) begin
         step();
         e = {STOP, 1'b0, 1'b1, 1'b0, 1'b0};
         if (obs() !== e) begin failures++; $display("FAIL toggle_restart cyc=%0d got=%h want=%h", k, obs(), e); end
         checks++;
      end
      step();
      e = {9'h020, 1'b1, 1'b0, 1'b0, 1'b0};
      if (obs() !== e) begin failures++; $display("FAIL toggle_man_out got=%h want=%h", obs(), e); end
      checks++;
      manual_on = 1'b0;
      for (int k = 0; k < DT; k++) begin
         step();
         e = {STOP, 1'b0, 1'b1, 1'b0, 1'b0};
         if (obs() !== e) begin failures++; $display("FAIL switch_to_auto_dt cyc=%0d got=%h want=%h", k, obs(), e); end
         checks++;
      end
      step();
      e = {9'h010, 1'b0, 1'b0, 1'b0, 1'b0};
      if (obs() !== e) begin failures++; $display("FAIL switch_auto_out got=%h want=%h", obs(), e); end
      checks++;
      cur = 9'h010;
   endtask

   task automatic test_watchdog();
      logic [12:0] e;
      bit          tmo;
      man_cmd   = 9'h020;
      man_valid = 1'b0;
      manual_on = 1'b1;
      for (int k = 0; k < DT; k++) step();
      step();
      since = 0;
      for (int k = 0; k < WD + 3; k++) begin
         step();
         since++;
         tmo = WD_EN && (since >= WD);
         e = {tmo ? STOP : 9'h020, 1'b1, 1'b0, tmo, 1'b0};
         if (obs() !== e) begin failures++; $display("FAIL wd_idle n=%0d got=%h want=%h", since, obs(), e); end
         checks++;
      end
      man_cmd   = 9'h008;
      man_valid = 1'b1;
      step();
      man_valid = 1'b0;
      since = 0;
      e = {9'h008, 1'b1, 1'b0, 1'b0, 1'b0};
      if (obs() !== e) begin failures++; $display("FAIL wd_recover got=%h want=%h", obs(), e); end
      checks++;
      for (int k = 0; k < WD - 1; k++) begin
         step();
         since++;
      end
      man_valid = 1'b1;
      step();
      man_valid = 1'b0;
      since = 0;
      e = {9'h008, 1'b1, 1'b0, 1'b0, 1'b0};
      if (obs() !== e) begin failures++; $display("FAIL wd_valid_wins got=%h want=%h", obs(), e); end
      checks++;
      for (int k = 0; k < WD; k++) begin
         step();
         since++;
         tmo = WD_EN && (since >= WD);
         e = {tmo ? STOP : 9'h008, 1'b1, 1'b0, tmo, 1'b0};
         if (obs() !== e) begin failures++; $display("FAIL wd_second n=%0d got=%h want=%h", since, obs(), e); end
         checks++;
      end
      man_valid = 1'b1;
      step();
      man_valid = 1'b0;
      since = 0;
      cur = 9'h008;
   endtask

   task automatic test_manual();
      logic [8:0]  nw;
      logic [12:0] e;
      for (int i = 0; i < 20; i++) begin
         nw = rand_valid();
         man_cmd   = nw;
         man_valid = 1'b1;
         if (reversal(cur, nw)) begin
            for (int k = 0; k < DT; k++) begin
               step();
               man_valid = 1'b0;
               e = {STOP, 1'b0, 1'b1, 1'b0, 1'b0};
               if (obs() !== e) begin failures++; $display("FAIL man_reversal_stop i=%0d got=%h want=%h", i, obs(), e); end
               checks++;
            end
         end
         step();
         man_valid = 1'b0;
         e = {nw, 1'b1, 1'b0, 1'b0, 1'b0};
         if (obs() !== e) begin failures++; $display("FAIL man_follow i=%0d got=%h want=%h", i, obs(), e); end
         checks++;
         cur = nw;
      end
   endtask

   task automatic test_estop();
      logic [12:0] e;
      estop = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         e = {STOP, 1'b0, 1'b0, 1'b0, 1'b0};
         if (obs() !== e) begin failures++; $display("FAIL estop_stop cyc=%0d got=%h want=%h", k, obs(), e); end
         checks++;
      end
      estop = 1'b0;
      step();
      e = {STOP, 1'b0, 1'b0, 1'b0, 1'b0};
      if (obs() !== e) begin failures++; $display("FAIL estop_idle got=%h want=%h", obs(), e); end
      checks++;
      for (int k = 0; k < DT; k++) begin
         step();
         e = {STOP, 1'b0, 1'b1, 1'b0, 1'b0};
         if (obs() !== e) begin failures++; $display("FAIL estop_dt cyc=%0d got=%h want=%h", k, obs(), e); end
         checks++;
      end
      step();
      e = {cur, 1'b1, 1'b0, 1'b0, 1'b0};
      if (obs() !== e) begin failures++; $display("FAIL estop_resume got=%h want=%h", obs(), e); end
      checks++;
   endtask

   task automatic test_rst_mid();
      logic [12:0] e;
      auto_cmd  = 9'h010;
      manual_on = 1'b0;
      for (int k = 0; k < 2; k++) begin
         step();
         e = {STOP, 1'b0, 1'b1, 1'b0, 1'b0};
         if (obs() !== e) begin failures++; $display("FAIL rstmid_dt cyc=%0d got=%h want=%h", k, obs(), e); end
         checks++;
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      e = {STOP, 1'b0, 1'b0, 1'b0, 1'b0};
      if (obs() !== e) begin failures++; $display("FAIL rstmid_reset got=%h want=%h", obs(), e); end
      checks++;
      for (int k = 0; k < DT; k++) begin
         step();
         e = {STOP, 1'b0, 1'b1, 1'b0, 1'b0};
         if (obs() !== e) begin failures++; $display("FAIL rstmid_restart cyc=%0d got=%h want=%h", k, obs(), e); end
         checks++;
      end
      step();
      e = {9'h010, 1'b0, 1'b0, 1'b0, 1'b0};
      if (obs() !== e) begin failures++; $display("FAIL rstmid_resume got=%h want=%h", obs(), e); end
      checks++;
   endtask

   initial begin
      test_reset();
      test_auto();
      test_invalid();
      test_mode_switch();
      test_watchdog();
      test_manual();
      test_estop();
      test_rst_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
